// File: rtl/key_note_decoder.sv
// key_note_decoder: debounced scan-code to note decoder with tone generator.
// Ports: clock, k_tr (async active-low reset), key_code[7:0] scan codes in;
// gate, note[3:0], note_on, note_off, tone, note_count[7:0],
// dur_out[15:0], dur_valid out.
// Define KEY_NOTE_DURATION_EN to enable the held-duration counter.
module key_note_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int HP_SCALE = 0
) (
  input  logic        clock,
  input  logic        k_tr,
  input  logic [7:0]  key_code,
  output logic        gate,
  output logic [3:0]  note,
  output logic        note_on,
  output logic        note_off,
  output logic        tone,
  output logic [7:0]  note_count,
  output logic [15:0] dur_out,
  output logic        dur_valid
);
  typedef enum logic [1:0] {IDLE, HOLD, SWITCH} state_t;
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  localparam logic [8:0] HP_TBL [16] = '{9'd0, 9'd478, 9'd426, 9'd379, 9'd358,
    9'd319, 9'd284, 9'd253, 9'd239, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
  state_t state, state_n;
  logic [3:0] idx, smp, cand, pend, pend_n, note_n;
  logic gate_n, on_n, off_n, commit;
  logic [12:0] hp, div;
  always_comb begin
    case (key_code)
      8'h2B: idx = 4'd1;
      8'h34: idx = 4'd2;
      8'h33: idx = 4'd3;
      8'h3B: idx = 4'd4;
      8'h42: idx = 4'd5;
      8'h4B: idx = 4'd6;
      8'h4C: idx = 4'd7;
      8'h52: idx = 4'd8;
      default: idx = 4'd0;
    endcase
  end
  // cand counts how many consecutive samples smp has held; a commit is
  // asserted as a level for as long as the count sits at its saturation value
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      smp <= '0;
      cand <= '0;
    end else begin
      smp <= idx;
      cand <= (idx != smp) ? 4'd1 : (cand == SC) ? cand : cand + 4'd1;
    end
  end
  assign commit = (cand == SC);
  always_comb begin
    state_n = state;
    note_n = note;
    pend_n = pend;
    gate_n = gate;
    on_n = 1'b0;
    off_n = 1'b0;
    case (state)
      IDLE: if (commit && smp != 4'd0) begin
        state_n = HOLD;
        note_n = smp;
        gate_n = 1'b1;
        on_n = 1'b1;
      end
      HOLD: if (commit && smp != note) begin
        off_n = 1'b1;
        gate_n = 1'b0;
        state_n = (smp == 4'd0) ? IDLE : SWITCH;
        note_n = (smp == 4'd0) ? 4'd0 : note;
        pend_n = smp;
      end
      SWITCH: begin
        state_n = HOLD;
        note_n = pend;
        gate_n = 1'b1;
        on_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign hp = 13'(HP_TBL[note]) << HP_SCALE;
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      state <= IDLE;
      note <= '0;
      pend <= '0;
      gate <= 1'b0;
      note_on <= 1'b0;
      note_off <= 1'b0;
      note_count <= '0;
      div <= '0;
      tone <= 1'b0;
    end else begin
      state <= state_n;
      note <= note_n;
      pend <= pend_n;
      gate <= gate_n;
      note_on <= on_n;
      note_off <= off_n;
      note_count <= on_n ? note_count + 8'd1 : note_count;
      // keyed off the next gate so tone is already 0 in the first gate-low cycle
      if (on_n || !gate_n) begin
        div <= '0;
        tone <= 1'b0;
      end else if (div == hp - 13'd1) begin
        div <= '0;
        tone <= ~tone;
      end else begin
        div <= div + 13'd1;
      end
    end
  end
`ifdef KEY_NOTE_DURATION_EN
  logic [15:0] dur, dur_inc;
  assign dur_inc = (&dur) ? dur : dur + 16'd1;
  // dur_out takes the incremented value so the closing HOLD cycle is counted
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      dur <= '0;
      dur_out <= '0;
      dur_valid <= 1'b0;
    end else begin
      dur <= on_n ? 16'd0 : (state == HOLD) ? dur_inc : dur;
      dur_valid <= off_n;
      if (off_n) dur_out <= dur_inc;
    end
  end
`else
  assign dur_out = '0;
  assign dur_valid = 1'b0;
`endif
endmodule

// File: tb/tb_key_note_decoder.sv
// tb_key_note_decoder: directed and random scan-code stimulus against a behavioural note model.
module tb_key_note_decoder;
  localparam int SC = 2;
  localparam int HPS = 0;
  logic clock = 1'b0;
  logic k_tr = 1'b0;
  logic [7:0] key_code = 8'hF0;
  logic gate, note_on, note_off, tone, dur_valid;
  logic [3:0] note;
  logic [7:0] note_count;
  logic [15:0] dur_out;
  int checks = 0;
  int errors = 0;
  logic [7:0] codes [8] = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52};
  int tbl [9] = '{0, 478, 426, 379, 358, 319, 284, 253, 239};
  int hist [$];
  int m_note, m_pend, m_cnt, ph, m_dur;
  bit m_gate, m_sw, m_on, m_off, m_dv;

  always #5 clock = ~clock;

  key_note_decoder #(.STABLE_CYCLES(SC), .HP_SCALE(HPS)) dut (
    .clock(clock), .k_tr(k_tr), .key_code(key_code), .gate(gate), .note(note),
    .note_on(note_on), .note_off(note_off), .tone(tone), .note_count(note_count),
    .dur_out(dur_out), .dur_valid(dur_valid)
  );

  function automatic int map(logic [7:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i + 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_note = 0; m_pend = 0; m_cnt = 0; ph = 0; m_dur = 0;
    m_gate = 0; m_sw = 0; m_on = 0; m_off = 0; m_dv = 0;
  endtask

  // one rising edge: react to the debounced key seen so far, then record the new sample
  task automatic model_edge(logic [7:0] kc);
    int c;
    bit cv;
    cv = hist.size() >= SC;
    c = cv ? hist[hist.size() - 1] : 0;
    if (cv) for (int i = 1; i <= SC; i++) if (hist[hist.size() - i] != c) cv = 0;
    m_on = 0; m_off = 0; m_dv = 0;
    ph++;
    if (m_sw) begin
      m_sw = 0; m_gate = 1; m_note = m_pend; m_on = 1;
    end else if (cv && !m_gate && c != 0) begin
      m_gate = 1; m_note = c; m_on = 1;
    end else if (cv && m_gate && c != m_note) begin
      m_off = 1; m_gate = 0;
      if (c == 0) m_note = 0;
      else begin m_sw = 1; m_pend = c; end
    end
`ifdef KEY_NOTE_DURATION_EN
    if (m_off) begin m_dv = 1; m_dur = (ph > 65535) ? 65535 : ph; end
`endif
    if (m_on) begin m_cnt = (m_cnt + 1) % 256; ph = 0; end
    hist.push_back(map(kc));
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic check_all(string tag);
    int t;
    t = m_gate ? (ph / (tbl[m_note] << HPS)) % 2 : 0;
    chk({tag, ".gate"}, gate, m_gate);
    chk({tag, ".note"}, note, m_note);
    chk({tag, ".note_on"}, note_on, m_on);
    chk({tag, ".note_off"}, note_off, m_off);
    chk({tag, ".tone"}, tone, t);
    chk({tag, ".note_count"}, note_count, m_cnt);
    chk({tag, ".dur_out"}, dur_out, m_dur);
    chk({tag, ".dur_valid"}, dur_valid, m_dv);
  endtask

  task automatic tick(logic [7:0] kc, string tag);
    key_code = kc;
    @(posedge clock);
    model_edge(kc);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    k_tr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(8'h2B, "s030_press");
      if (i == 2) chk("s030_on_edge", note_on, 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick(8'hF0, "s030_release");
      if (i == 2) chk("s030_off_edge", note_off, 1);
    end
    chk("s030_count", note_count, 1);
    repeat (1000) tick(8'h52, "s031_tone");
    repeat (4) tick(8'hF0, "s031_release");
    repeat (6) tick(8'h33, "s032_hold33");
    repeat (6) tick(8'h42, "s032_to42");
    chk("s032_note", note, 5);
    repeat (4) tick(8'hF0, "s032_release");
    repeat (300) tick(8'h34, "s033_hold");
    tick(8'hF0, "s033_glitch");
    repeat (300) tick(8'h34, "s033_after");
    repeat (4) tick(8'hF0, "s033_release");
    repeat (100) tick(8'h3B, "s035_hold");
    repeat (3) tick(8'hF0, "s035_release");
`ifdef KEY_NOTE_DURATION_EN
    chk("s035_dur", dur_out, 100);
`else
    chk("s035_dur", dur_out, 0);
`endif
    repeat (5) tick(8'h2B, "s034_hold");
    #2;
    k_tr = 1'b0;
    #1;
    model_reset();
    chk("s034_async_gate", gate, 0);
    chk("s034_async_note", note, 0);
    chk("s034_async_count", note_count, 0);
    chk("s034_async_off", note_off, 0);
    check_all("s034_async");
    @(negedge clock);
    k_tr = 1'b1;
    repeat (256) begin
      repeat (3) tick(8'h4C, "s034_press");
      repeat (3) tick(8'hF0, "s034_release");
    end
    chk("s034_wrap", note_count, 0);
    repeat (150) begin
      int k;
      logic [7:0] kc;
      k = $urandom_range(0, 9);
      kc = (k < 8) ? codes[k] : (k == 8) ? 8'hF0 : 8'($urandom);
      repeat ($urandom_range(1, 8)) tick(kc, "rand");
    end
    repeat (4) tick(8'hF0, "final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_note_decoder.md
KEY_NOTE_DECODER -- requirements
Module: key_note_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, is the number of consecutive identical samples needed to commit a code (legal range 1..15).
REQ-002 Parameter HP_SCALE, default 0, is the left-shift applied to every tone half-period entry (legal range 0..4).
REQ-003 Port clock, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port k_tr, input, 1 bit, is the reset: asynchronous, active-low.
REQ-005 Port key_code, input, 8 bits, carries the scan-code stream (make code while held, 8'hF0 when released).
REQ-006 Port gate, output, 1 bit, is high while a note is held.
REQ-007 Port note, output, 4 bits, is the committed note index (0 means none, 1..8 are valid notes).
REQ-008 Port note_on, output, 1 bit, is a one-cycle pulse at note start.
REQ-009 Port note_off, output, 1 bit, is a one-cycle pulse at note end.
REQ-010 Port tone, output, 1 bit, is the square-wave audio output.
REQ-011 Port note_count, output, 8 bits, counts note_on pulses.
REQ-012 Port dur_out, output, 16 bits, is the last held duration in clocks.
REQ-013 Port dur_valid, output, 1 bit, is a one-cycle pulse marking an update of dur_out.

Function
REQ-014 key_code SHALL be mapped to an index as follows: 2B=1, 34=2, 33=3, 3B=4, 42=5, 4B=6, 4C=7, 52=8; every other code, including F0, SHALL map to 0.
REQ-015 The mapped index SHALL be registered each clock; a candidate counter SHALL reset to 1 when the index differs from the previous sample and SHALL otherwise increment, saturating at STABLE_CYCLES.
REQ-016 The index SHALL be committed when the candidate count reaches STABLE_CYCLES; a new index present before edge E0 SHALL therefore commit at edge E0+STABLE_CYCLES.
REQ-017 The FSM SHALL have the states IDLE, HOLD and SWITCH, with the following transitions:
  - IDLE to HOLD on a committed nonzero index: note loads the index, gate=1, note_on=1.
  - HOLD to IDLE on a committed index of 0: note_off=1, gate=0, note=0.
  - HOLD to SWITCH on a committed nonzero index different from note: note_off=1, gate=0; the new index is held pending.
  - SWITCH to HOLD unconditionally on the next cycle: note loads the pending index, gate=1, note_on=1.
  - A committed index equal to the current state's note, or 0 while in IDLE, SHALL cause no action.
REQ-018 note_on and note_off SHALL be registered pulses lasting exactly one cycle and SHALL never be high in the same cycle.
REQ-019 The tone half-period SHALL be table[note] << HP_SCALE, with table entries 1..8 = 478, 426, 379, 358, 319, 284, 253, 239 clocks.
REQ-020 The tone divider counter SHALL clear and tone SHALL go 0 on every note_on; while gate=1, tone SHALL toggle when the counter reaches half-period-1 and the counter SHALL then wrap to 0.
REQ-021 While gate=0, tone SHALL be 0 and the divider counter SHALL be held at 0.
REQ-022 note_count SHALL increment on each note_on and wrap from 255 to 0.
REQ-023 A key_code change that lasts fewer than STABLE_CYCLES samples SHALL have no effect on any output.

Reset
REQ-024 While k_tr=0, all outputs, the FSM (IDLE), the sample, candidate, divider and duration registers SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted during HOLD SHALL emit no note_off and no dur_valid pulse.
REQ-026 After k_tr deasserts, the first sample SHALL be taken at the next rising edge of clock, and commit counting SHALL start from that sample.

Configuration
REQ-027 When macro KEY_NOTE_DURATION_EN is defined, a 16-bit counter SHALL clear on note_on, increment every cycle in HOLD and saturate at FFFF.
REQ-028 When KEY_NOTE_DURATION_EN is defined, the counter value SHALL be copied to dur_out on each note_off, with dur_valid=1 in that same cycle.
REQ-029 When KEY_NOTE_DURATION_EN is undefined, dur_out SHALL be 0 and dur_valid SHALL be 0 permanently, and no counter logic SHALL exist.

Verification
REQ-030 Scenario: after reset, key_code=2B held for 10 clocks, then F0 -> note_on 2 edges after the first 2B sample, note=1, gate=1; note_off 2 edges after the first F0 sample; note_count=1.
REQ-031 Scenario: with HP_SCALE=0, key_code=52 held -> tone period is 478 clocks (239 high, 239 low), with the first rising edge of tone 239 clocks after note_on.
REQ-032 Scenario: during HOLD of 33, key_code changes directly to 42 -> note_off pulse, then note_on in the next cycle with note=5, and gate low for exactly 1 cycle.
REQ-033 Scenario: during HOLD of 34, a 1-cycle glitch to F0 (STABLE_CYCLES=2) -> no note_off, and tone keeps running uninterrupted.
REQ-034 Scenario: k_tr pulsed low mid-HOLD -> all outputs 0 asynchronously, no note_off pulse; 256 note_on events after reset -> note_count=0.
REQ-035 Scenario: with KEY_NOTE_DURATION_EN defined, hold 3B for 100 commit-to-commit clocks -> dur_valid with dur_out=100 (99 when STABLE_CYCLES timing is offset by SWITCH); without the macro -> dur_out stays 0.
